// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - memory-stage request bus plus external 16-bit SRAM pins
interface sram_controller_if #(
    parameter int SRAM_ADDR_WIDTH = 18
);
    logic                       memoryReadEnabled;
    logic                       memoryWriteEnabled;
    logic [31:0]                address;
    logic [31:0]                writeData;
    logic [31:0]                readData;
    logic                       ready;
    logic [SRAM_ADDR_WIDTH-1:0] sramAddress;
    logic [15:0]                sramDqOut;
    logic                       sramDqOe;
    logic [15:0]                sramDqIn;
    logic                       sramWeN;

    modport master (
        output memoryReadEnabled, memoryWriteEnabled, address, writeData, sramDqIn,
        input  readData, ready, sramAddress, sramDqOut, sramDqOe, sramWeN
    );

    modport slave (
        input  memoryReadEnabled, memoryWriteEnabled, address, writeData, sramDqIn,
        output readData, ready, sramAddress, sramDqOut, sramDqOe, sramWeN
    );
endinterface

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - serves 32-bit pipeline accesses as two timed 16-bit SRAM halves
module sram_controller #(
    parameter logic [31:0] BASE_ADDR       = 32'd1024,
    parameter int          WAIT_CYCLES     = 2,
    parameter int          SRAM_ADDR_WIDTH = 18
) (
    input logic              clk,
    input logic              rst,
    sram_controller_if.slave bus
);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;

    state_t                     state;
    state_t                     next_state;
    logic [CW-1:0]              count;
    logic                       op_write;
    logic [31:0]                addr_q;
    logic [31:0]                data_q;
    logic [15:0]                held_low;
    logic [31:0]                read_data_q;
    logic [31:0]                offset;
    logic [SRAM_ADDR_WIDTH-2:0] word_addr;
    logic                       request;
    logic                       last;
    logic                       unused_offset;

    assign request       = bus.memoryReadEnabled | bus.memoryWriteEnabled;
    assign last          = (count == LAST);
    // Subtraction wraps, so addresses below the base land at the top of the SRAM.
    assign offset        = addr_q - BASE_ADDR;
    assign word_addr     = offset[SRAM_ADDR_WIDTH:2];
    assign unused_offset = ^{offset[31:SRAM_ADDR_WIDTH+1], offset[1:0]};
    assign bus.readData  = read_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (request) next_state = LOW;
            LOW:     if (last) next_state = HIGH;
            HIGH:    if (last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            op_write    <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            held_low    <= '0;
            read_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        addr_q   <= bus.address;
                        data_q   <= bus.writeData;
                        op_write <= bus.memoryWriteEnabled;
                        count    <= '0;
                    end
                end
                LOW: begin
                    count <= last ? '0 : count + CW'(1);
                    if (last && !op_write) held_low <= bus.sramDqIn;
                end
                HIGH: begin
                    count <= last ? '0 : count + CW'(1);
                    if (last && !op_write) read_data_q <= {bus.sramDqIn, held_low};
                end
                default: ;
            endcase
        end
    end

    // Reset forces ready high so a pipeline held in reset is never frozen.
    always_comb begin
        bus.ready       = !rst || (state == IDLE && !request) || (state == DONE);
        bus.sramAddress = '0;
        bus.sramDqOut   = '0;
        bus.sramDqOe    = 1'b0;
        bus.sramWeN     = 1'b1;
        if (state == LOW || state == HIGH) begin
            bus.sramAddress = {word_addr, state == HIGH};
            if (op_write) begin
                bus.sramDqOut = (state == HIGH) ? data_q[31:16] : data_q[15:0];
                bus.sramDqOe  = 1'b1;
                bus.sramWeN   = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - scoreboard bench for sram_controller with a word-level memory model
module tb_sram_controller;
    localparam int          W    = 2;
    localparam int          AW   = 18;
    localparam int unsigned BASE = 1024;

    typedef struct {
        bit          wr;
        int unsigned word;
        logic [31:0] data;
        logic [31:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_controller_if #(.SRAM_ADDR_WIDTH(AW)) bus ();

    sram_controller #(
        .BASE_ADDR      (32'(BASE)),
        .WAIT_CYCLES    (W),
        .SRAM_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [15:0] sram [(1 << AW)] = '{default: 16'h0};
    logic        pre_en   = 1'b0;
    int unsigned pre_addr = 0;
    logic [31:0] pre_data = '0;

    assign bus.sramDqIn = sram[bus.sramAddress];

    always @(posedge clk) begin
        if (!bus.sramWeN) sram[bus.sramAddress] <= bus.sramDqOut;
        if (pre_en) begin
            sram[pre_addr]     <= pre_data[15:0];
            sram[pre_addr + 1] <= pre_data[31:16];
        end
    end

    exp_t        sb[$];
    int unsigned ref_mem [int unsigned];
    logic [31:0] last_rd = '0;
    int          n_cmp   = 0;
    int          n_err   = 0;
    bit          mon_en  = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int unsigned word_of(logic [31:0] a);
        logic [31:0] d;
        d = a - 32'(BASE);
        return (d >> 2) % (1 << (AW - 1));
    endfunction

    task automatic issue(bit re, bit we, logic [31:0] a, logic [31:0] d);
        exp_t e;
        int   n;
        e.wr   = we;
        e.word = word_of(a);
        e.data = d;
        if (we) begin
            ref_mem[e.word] = d;
            e.rd = last_rd;
        end else begin
            e.rd = ref_mem.exists(e.word) ? 32'(ref_mem[e.word]) : 32'h0;
            last_rd = e.rd;
        end
        sb.push_back(e);
        bus.memoryReadEnabled  = re;
        bus.memoryWriteEnabled = we;
        bus.address            = a;
        bus.writeData          = d;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.ready) break;
            n++;
            if (n > 20) begin
                n_cmp++;
                n_err++;
                $display("FAIL issue_timeout: ready low for %0d cycles, required %0d", n, 2 * W + 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.memoryReadEnabled  = 1'b0;
        bus.memoryWriteEnabled = 1'b0;
    endtask

    int   k = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (!mon_en || !rst) begin
            k = 0;
        end else if (!bus.ready) begin
            if (k == 0) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow: access seen with no expected entry");
                end else begin
                    cur = sb[0];
                end
                check("idle_wen", 32'(bus.sramWeN), 32'd1);
            end else if (k <= 2 * W) begin
                int unsigned ph;
                ph = (k > W) ? 1 : 0;
                check("sram_addr", 32'(bus.sramAddress), cur.word * 2 + ph);
                if (cur.wr) begin
                    check("wr_wen", 32'(bus.sramWeN), 32'd0);
                    check("wr_oe", 32'(bus.sramDqOe), 32'd1);
                    check("wr_dq", 32'(bus.sramDqOut), ph == 1 ? cur.data >> 16 : cur.data & 32'hFFFF);
                end else begin
                    check("rd_wen", 32'(bus.sramWeN), 32'd1);
                    check("rd_oe", 32'(bus.sramDqOe), 32'd0);
                end
            end
            k++;
            if (k > 2 * W + 1) begin
                check("freeze_len", 32'(k), 32'(2 * W + 1));
                k = 0;
            end
        end else if (k > 0) begin
            check("freeze_len", 32'(k), 32'(2 * W + 1));
            check("read_data", bus.readData, cur.rd);
            check("done_wen", 32'(bus.sramWeN), 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            k = 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.memoryReadEnabled  = 1'b1;
        bus.memoryWriteEnabled = 1'b1;
        bus.address            = 32'd1024;
        bus.writeData          = 32'h12345678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_wen", 32'(bus.sramWeN), 32'd1);
        check("rst_oe", 32'(bus.sramDqOe), 32'd0);
        check("rst_rdata", bus.readData, 32'd0);
        check("rst_addr", 32'(bus.sramAddress), 32'd0);
        bus.memoryReadEnabled  = 1'b0;
        bus.memoryWriteEnabled = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        issue(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        pre_addr = 8;
        pre_data = 32'h12345678;
        pre_en   = 1'b1;
        @(posedge clk);
        #1;
        pre_en     = 1'b0;
        ref_mem[4] = 32'h12345678;
        issue(1'b1, 1'b0, 32'd1032, 32'h0);
        issue(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D);
        issue(1'b1, 1'b0, 32'd1028, 32'h0);
        issue(1'b1, 1'b1, 32'd1024, 32'h11112222);
        issue(1'b1, 1'b0, 32'd1027, 32'h0);
        issue(1'b0, 1'b1, 32'(BASE - 4), 32'hA5A55A5A);
        issue(1'b1, 1'b0, 32'(BASE - 2), 32'h0);

        mon_en = 1'b0;
        bus.memoryWriteEnabled = 1'b1;
        bus.address            = 32'(BASE + 400);
        bus.writeData          = 32'h0BADF00D;
        repeat (3) @(posedge clk);
        #1;
        check("pre_abort_wen", 32'(bus.sramWeN), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_wen", 32'(bus.sramWeN), 32'd1);
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_oe", 32'(bus.sramDqOe), 32'd0);
        bus.memoryWriteEnabled = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        last_rd = '0;
        mon_en  = 1'b1;
        issue(1'b1, 1'b0, 32'(BASE + 404), 32'h0);

        for (int i = 0; i < 60; i++) begin
            int unsigned r;
            logic [31:0] a;
            r = $urandom_range(0, 7);
            if ($urandom_range(0, 7) == 0)
                a = 32'(BASE) - 32'(4 * $urandom_range(1, 3)) + 32'($urandom_range(0, 3));
            else
                a = 32'(BASE) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if (r == 0)      issue(1'b1, 1'b1, a, $urandom);
            else if (r < 4)  issue(1'b0, 1'b1, a, $urandom);
            else             issue(1'b1, 1'b0, a, 32'h0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
